fxp_sat_accumulator: RTL and testbench
======================================

// Module: fxp_sat_accumulator
// PURPOSE
//  Downstream consumer of the Q2.14 fixed-point adder stage. Takes the adder's registered sum and its
//  overflow/underflow flags, and accumulates a frame of LEN samples with per-step saturation.
//  Presents the frame total on a valid/ready output, with sticky saturation and flag-seen status.
//  Feeds the frame result to the next processing stage.
// PARAMETERS
//  data_width  16  total sample/accumulator width (two's complement)
//  frac_width  14  fractional bits (Q2.14 at defaults)
//  int_width   2   integer bits incl. sign; data_width = int_width + frac_width
//  cnt_width   8   width of frame length and sample counter
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           asynchronous, active-low reset
//  len            in   cnt_width   samples per frame, sampled on the first accepted sample of a frame
//  in_valid       in   1           in_data/in_ovf/in_udf valid
//  in_ready       out  1           block can accept a sample
//  in_data        in   data_width  signed Q sample (adder out)
//  in_ovf         in   1           adder overflow_flag for this sample
//  in_udf         in   1           adder underflow_flag for this sample
//  out_valid      out  1           frame result valid
//  out_ready      in   1           consumer accepts result
//  out_data       out  data_width  signed saturated frame sum
//  out_sat        out  1           accumulator clamped at least once in this frame
//  out_flag_seen  out  1           at least one input sample in this frame had in_ovf or in_udf set
// BEHAVIOUR
//  - Reset (reset=0, async)
//    - state=IDLE; acc, cnt, len_q = 0.
//    - in_ready, out_valid, out_data, out_sat, out_flag_seen = 0.
//    - in_ready is registered and rises on the first clk edge after reset deasserts.
//  - Accept/handshakes
//    - Input accept = in_valid & in_ready.
//    - Output handshake completes on out_valid & out_ready.
//  - FSM
//    - IDLE: in_ready=1.
//      - Accept: len_q = (len==0) ? 1 : len; acc = sat(0 + x); cnt = 1.
//      - Then go to DONE if len_q==1, else go to ACC.
//    - ACC: in_ready=1.
//      - Accept: acc = sat(acc + x); cnt = cnt + 1.
//      - Go to DONE when the new cnt == len_q.
//      - No accept: hold state.
//    - DONE: in_ready=0; out_valid=1.
//      - out_data/out_sat/out_flag_seen are stable until the handshake.
//      - out_ready=1: go to IDLE. out_valid and in_ready update on that same edge (in_ready=1).
//  - Registered outputs
//    - in_ready is registered from next-state. It is 0 from the edge that accepts the last sample of a frame.
//  - Latency
//    - out_valid rises on the edge that accepts the last sample (result visible the following cycle).
//    - A full round trip per frame is LEN accepts + 1 output cycle minimum.
//  - Sample conditioning
//    - in_ovf=1: x = max_pos (0x7FFF), in_ovf takes priority.
//    - in_ovf=0, in_udf=1: x = max_neg (0x8000).
//    - Otherwise x = in_data.
//    - Either flag set sets the frame's flag_seen.
//  - Arithmetic
//    - sum = sign-extend(acc) + sign-extend(x) at data_width+1 bits.
//    - sum > max_pos: acc = max_pos, sat=1. sum < max_neg: acc = max_neg, sat=1. Otherwise acc = sum[data_width-1:0].
//    - Exact max_pos/max_neg results do not set sat. Saturation is per step, and later samples move acc off the rail.
//  - Sticky status
//    - sat and flag_seen clear at frame start (IDLE accept), set as above, and copy to out_* on entry to DONE.
//  - Other rules
//    - len changes outside IDLE are ignored.
//    - Reset mid-frame discards the partial frame; the next frame starts clean.
// TESTING
//  - len=3; 0x000C, 0x0003, 0x0018; out_ready=1 -> out_data=0x0027, sat=0, flag_seen=0.
//    - out_valid is high exactly one cycle.
//  - len=2; 0x7FFF, 0x0001 -> out_data=0x7FFF, out_sat=1.
//  - len=3; 0x7FFF, 0x0001, 0xFFFF -> out_data=0x7FFE, out_sat=1 (recovers from the rail).
//  - Negative rail: len=2; 0xC000, 0xC000 -> 0x8000, sat=0.
//    - Then len=3; 0xC000, 0xC000, 0xFFFF -> 0x8000, sat=1.
//  - len=0 -> frame of 1 sample; in_data=0x1234:
//    - in_ovf=1 -> 0x7FFF, flag_seen=1, sat=0.
//    - Next frame, in_udf=1 -> 0x8000.
//  - Backpressure and reset mid-frame:
//    - out_ready=0 for 5 cycles -> out_valid=1 and out_* stable, in_ready=0, in_valid ignored.
//    - reset pulse after 2 of 4 samples -> all outputs 0; next frame sums only new samples.

Source files
------------

// File: rtl/fxp_sat_accumulator.sv
// fxp_sat_accumulator
//   Accumulates a frame of len signed fixed-point samples from the adder stage with
//   per-step saturation, then presents the frame total on a valid/ready output
//   together with sticky "clamped" and "adder flag seen" status.
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   len               samples per frame (0 treated as 1), sampled on the first accept of a frame
//   in_valid/in_ready input handshake; in_data/in_ovf/in_udf are the adder sum and flags
//   out_valid/out_ready output handshake; out_data/out_sat/out_flag_seen frame result
module fxp_sat_accumulator #(
    parameter int unsigned data_width = 16,
    parameter int unsigned frac_width = 14,
    parameter int unsigned int_width  = 2,
    parameter int unsigned cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [cnt_width-1:0]  len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_ovf,
    input  logic                  in_udf,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_sat,
    output logic                  out_flag_seen
);

    localparam int unsigned sum_width = data_width + 1;
    localparam logic [data_width-1:0] max_pos = {1'b0, {(data_width-1){1'b1}}};
    localparam logic [data_width-1:0] max_neg = {1'b1, {(data_width-1){1'b0}}};

    // Format sanity: the Q format must fill the sample width exactly.
    if (data_width != int_width + frac_width) begin : g_bad_format
        $error("fxp_sat_accumulator: data_width must equal int_width + frac_width");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [data_width-1:0]  acc_q, acc_d;
    logic [cnt_width-1:0]   cnt_q, cnt_d;
    logic [cnt_width-1:0]   len_q, len_d;
    logic                   sat_q, sat_d;
    logic                   flag_q, flag_d;
    logic                   in_ready_d, out_valid_d;
    logic [data_width-1:0]  out_data_d;
    logic                   out_sat_d, out_flag_seen_d;

    logic                   accept;
    logic [data_width-1:0]  x;
    logic [data_width-1:0]  base;
    logic [sum_width-1:0]   sum;
    logic [data_width-1:0]  step_acc;
    logic                   step_sat;
    logic                   step_flag;
    logic [cnt_width-1:0]   len_eff;
    logic [cnt_width-1:0]   cnt_inc;

    // Sample conditioning and one saturating accumulation step.
    always_comb begin
        accept    = in_valid & in_ready;
        step_flag = in_ovf | in_udf;
        x         = in_data;
        if (in_ovf) begin
            x = max_pos;
        end else if (in_udf) begin
            x = max_neg;
        end
        // A new frame starts from zero rather than the stale accumulator.
        base = (state_q == IDLE) ? '0 : acc_q;
        sum  = {base[data_width-1], base} + {x[data_width-1], x};
        // The top two bits of the widened sum disagree exactly when the result left the range.
        step_acc = sum[data_width-1:0];
        step_sat = 1'b0;
        case (sum[sum_width-1 -: 2])
            2'b01: begin
                step_acc = max_pos;
                step_sat = 1'b1;
            end
            2'b10: begin
                step_acc = max_neg;
                step_sat = 1'b1;
            end
            default: ;
        endcase
        len_eff = (len == '0) ? cnt_width'(1) : len;
        cnt_inc = cnt_q + cnt_width'(1);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        len_d           = len_q;
        sat_d           = sat_q;
        flag_d          = flag_q;
        out_data_d      = out_data;
        out_sat_d       = out_sat;
        out_flag_seen_d = out_flag_seen;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d  = len_eff;
                    acc_d  = step_acc;
                    cnt_d  = cnt_width'(1);
                    sat_d  = step_sat;
                    flag_d = step_flag;
                    if (len_eff == cnt_width'(1)) begin
                        state_d         = DONE;
                        out_data_d      = step_acc;
                        out_sat_d       = step_sat;
                        out_flag_seen_d = step_flag;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d  = step_acc;
                    cnt_d  = cnt_inc;
                    sat_d  = sat_q | step_sat;
                    flag_d = flag_q | step_flag;
                    if (cnt_inc == len_q) begin
                        state_d         = DONE;
                        out_data_d      = step_acc;
                        out_sat_d       = sat_q | step_sat;
                        out_flag_seen_d = flag_q | step_flag;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state.
        in_ready_d  = (state_d != DONE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            len_q         <= '0;
            sat_q         <= 1'b0;
            flag_q        <= 1'b0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_sat       <= 1'b0;
            out_flag_seen <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            sat_q         <= sat_d;
            flag_q        <= flag_d;
            in_ready      <= in_ready_d;
            out_valid     <= out_valid_d;
            out_data      <= out_data_d;
            out_sat       <= out_sat_d;
            out_flag_seen <= out_flag_seen_d;
        end
    end

endmodule

// File: tb/tb_fxp_sat_accumulator.sv
// Bench for fxp_sat_accumulator: directed frames, an arithmetic frame model and a
// per-cycle output monitor.
module tb_fxp_sat_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        in_ovf = 1'b0;
    logic        in_udf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_flag_seen;

    fxp_sat_accumulator dut (
        .clk          (clk),
        .reset        (reset),
        .len          (len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_ovf       (in_ovf),
        .in_udf       (in_udf),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sat      (out_sat),
        .out_flag_seen(out_flag_seen)
    );

    always #5 clk = ~clk;

    // Counters: m_* stepped by the directed sequence, c_* by the monitor.
    int m_tests = 0, m_fails = 0;
    int c_tests = 0, c_fails = 0;
    int valid_cycles = 0;
    int post_rst = 0;

    // Expected frame results {flag_seen, sat, data}, oldest first.
    logic [17:0] exp_q[$];

    // Samples of the frame being built.
    logic [15:0] s_data[$];
    bit          s_ovf[$];
    bit          s_udf[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) post_rst <= 0;
        else if (post_rst < 2) post_rst <= post_rst + 1;
    end

    // Monitor: every cycle out of reset, check handshake consistency and the result.
    always @(negedge clk) begin
        if (reset && post_rst >= 1) begin
            c_tests++;
            if (in_ready !== !out_valid) begin
                c_fails++;
                $display("FAIL ready_vs_valid: in_ready=%b out_valid=%b (required in_ready = !out_valid)",
                         in_ready, out_valid);
            end
            if (out_valid === 1'b1) begin
                valid_cycles++;
                c_tests++;
                if (exp_q.size() == 0) begin
                    c_fails++;
                    $display("FAIL unexpected_result: out_valid=1 data=%h with no frame outstanding", out_data);
                end else begin
                    if ({out_flag_seen, out_sat, out_data} !== exp_q[0]) begin
                        c_fails++;
                        $display("FAIL frame_result: got flag=%b sat=%b data=%h, required flag=%b sat=%b data=%h",
                                 out_flag_seen, out_sat, out_data, exp_q[0][17], exp_q[0][16], exp_q[0][15:0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] req);
        m_tests++;
        if (act !== req) begin
            m_fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Frame model straight from the arithmetic rules, using plain integers.
    function automatic logic [17:0] model();
        int acc = 0;
        bit s = 0;
        bit f = 0;
        for (int i = 0; i < s_data.size(); i++) begin
            int x;
            if (s_ovf[i]) x = 32767;
            else if (s_udf[i]) x = -32768;
            else x = int'($signed(s_data[i]));
            f = f | s_ovf[i] | s_udf[i];
            acc = acc + x;
            if (acc > 32767) begin
                acc = 32767;
                s = 1;
            end else if (acc < -32768) begin
                acc = -32768;
                s = 1;
            end
        end
        return {f, s, 16'(acc)};
    endfunction

    task automatic add_s(input logic [15:0] d, input bit o, input bit u);
        s_data.push_back(d);
        s_ovf.push_back(o);
        s_udf.push_back(u);
    endtask

    // Present one sample and hold it until accepted. Starts and ends just after a posedge.
    task automatic send_sample(input logic [15:0] d, input bit o, input bit u);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_ovf   = o;
        in_udf   = u;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) mchk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            mchk("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Send the queued samples as one frame; the model result is pinned to a literal.
    task automatic run_frame(input logic [7:0] ln, input logic [15:0] ed, input bit es,
                             input bit ef, input bit drain);
        logic [17:0] e;
        e = model();
        mchk("model_vs_literal", {14'd0, e}, {14'd0, ef, es, ed});
        exp_q.push_back(e);
        len = ln;
        for (int i = 0; i < s_data.size(); i++) begin
            send_sample(s_data[i], s_ovf[i], s_udf[i]);
            if (i == 0) len = 8'hFF;
        end
        in_valid = 1'b0;
        in_ovf   = 1'b0;
        in_udf   = 1'b0;
        s_data.delete();
        s_ovf.delete();
        s_udf.delete();
        if (drain) wait_drain();
    endtask

    task automatic check_zero_outputs(input string tag);
        mchk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        mchk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        mchk({tag, "_out_data"}, 32'(out_data), 32'd0);
        mchk({tag, "_out_sat"}, 32'(out_sat), 32'd0);
        mchk({tag, "_out_flag_seen"}, 32'(out_flag_seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;
        #1;
        mchk("in_ready_before_first_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        mchk("in_ready_after_first_edge", 32'(in_ready), 32'd1);

        // Plain sum; result valid for exactly one cycle.
        vc0 = valid_cycles;
        add_s(16'h000C, 0, 0); add_s(16'h0003, 0, 0); add_s(16'h0018, 0, 0);
        run_frame(8'd3, 16'h0027, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        mchk("valid_one_cycle", 32'(valid_cycles - vc0), 32'd1);

        // Positive rail, then recovery off the rail.
        add_s(16'h7FFF, 0, 0); add_s(16'h0001, 0, 0);
        run_frame(8'd2, 16'h7FFF, 1, 0, 1);
        add_s(16'h7FFF, 0, 0); add_s(16'h0001, 0, 0); add_s(16'hFFFF, 0, 0);
        run_frame(8'd3, 16'h7FFE, 1, 0, 1);

        // Negative rail: exact hit does not saturate, going past does.
        add_s(16'hC000, 0, 0); add_s(16'hC000, 0, 0);
        run_frame(8'd2, 16'h8000, 0, 0, 1);
        add_s(16'hC000, 0, 0); add_s(16'hC000, 0, 0); add_s(16'hFFFF, 0, 0);
        run_frame(8'd3, 16'h8000, 1, 0, 1);

        // len=0 behaves as one sample; flag substitution.
        add_s(16'h1234, 1, 0);
        run_frame(8'd0, 16'h7FFF, 0, 1, 1);
        add_s(16'h1234, 0, 1);
        run_frame(8'd0, 16'h8000, 0, 1, 1);

        // Overflow flag wins over underflow; then push past the rail.
        add_s(16'h1234, 1, 1); add_s(16'h0001, 0, 0);
        run_frame(8'd2, 16'h7FFF, 1, 1, 1);

        // Single-sample frame with len=1.
        add_s(16'h0005, 0, 0);
        run_frame(8'd1, 16'h0005, 0, 0, 1);

        // Backpressure: result held, inputs refused.
        out_ready = 1'b0;
        add_s(16'h0100, 0, 0); add_s(16'h0100, 0, 0); add_s(16'h0100, 0, 0); add_s(16'h0100, 0, 0);
        run_frame(8'd4, 16'h0400, 0, 0, 0);
        in_valid = 1'b1;
        in_data  = 16'h5555;
        repeat (5) begin
            @(negedge clk);
            mchk("bp_in_ready", 32'(in_ready), 32'd0);
            mchk("bp_out_valid", 32'(out_valid), 32'd1);
            mchk("bp_out_data", 32'(out_data), 32'h0400);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset after 2 of 4 samples discards the partial frame.
        len = 8'd4;
        send_sample(16'h1000, 0, 0);
        send_sample(16'h1000, 0, 1);
        in_valid = 1'b0;
        in_udf   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check_zero_outputs("midreset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        add_s(16'h0010, 0, 0); add_s(16'h0020, 0, 0);
        run_frame(8'd2, 16'h0030, 0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        mchk("no_outstanding_frames", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", m_tests + c_tests, m_fails + c_fails);
        $finish;
    end

endmodule
